// File: rtl/dt_peak_scan.sv
// Raster scan of the distance-transform result map: global peak, foreground count
// and one row-maximum write per image row, launched by the engine's done level.
module dt_peak_scan #(
  parameter  int IMG_W = 128,
  parameter  int IMG_H = 128,
  localparam int AW    = $clog2(IMG_W * IMG_H),
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          res_rd,
  output logic [AW-1:0] res_addr,
  input  logic [7:0]    res_di,
  output logic          rmax_wr,
  output logic [RW-1:0] rmax_addr,
  output logic [7:0]    rmax_do,
  output logic [7:0]    peak_val,
  output logic [AW-1:0] peak_addr,
  output logic [AW:0]   fg_cnt,
  output logic          busy,
  output logic          scan_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic          r_rd;
  logic [AW-1:0] r_addr;
  logic          r_busy;
  logic          r_scanDone;
  logic          r_beatVld;
  logic [AW-1:0] r_beatAddr;
  logic [7:0]    r_acc;
  logic [7:0]    r_peakVal;
  logic [AW-1:0] r_peakAddr;
  logic [AW:0]   r_fgCnt;
  logic          r_rmaxWr;
  logic [RW-1:0] r_rmaxAddr;
  logic [7:0]    r_rmaxDo;

  logic          w_accept;
  logic          w_rdNext;
  logic          w_busyNext;
  logic          w_doneNext;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [7:0]    w_rowMax;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // DRAIN ends on the strobe of the last row, which trails the last read by two cycles.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = SCAN;
      SCAN:    if (r_addr == LAST_ADDR) w_nextState = DRAIN;
      DRAIN:   if (r_rmaxWr && (r_rmaxAddr == LAST_ROW)) w_nextState = DONE;
      DONE:    if (!start) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_accept   = (r_state == IDLE) && start;
    w_rdNext   = (w_nextState == SCAN);
    w_busyNext = (w_nextState == SCAN) || (w_nextState == DRAIN);
    w_doneNext = (w_nextState == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd       <= 1'b0;
      r_busy     <= 1'b0;
      r_scanDone <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_rd       <= w_rdNext;
      r_busy     <= w_busyNext;
      r_scanDone <= w_doneNext;
      if (w_accept)
        r_addr <= '0;
      else if ((r_state == SCAN) && (r_addr != LAST_ADDR))
        r_addr <= r_addr + AW'(1);
    end
  end

  // Tag each read with its address so the returning beat knows its row and column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beatVld  <= 1'b0;
      r_beatAddr <= '0;
    end else begin
      r_beatVld  <= r_rd;
      r_beatAddr <= r_addr;
    end
  end

  always_comb begin
    w_col    = r_beatAddr[CW-1:0];
    w_row    = r_beatAddr[AW-1:CW];
    w_rowMax = res_di;
    if ((w_col != '0) && (r_acc > res_di))
      w_rowMax = r_acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc      <= '0;
      r_peakVal  <= '0;
      r_peakAddr <= '0;
      r_fgCnt    <= '0;
    end else if (w_accept) begin
      r_acc      <= '0;
      r_peakVal  <= '0;
      r_peakAddr <= '0;
      r_fgCnt    <= '0;
    end else if (r_beatVld) begin
      r_acc <= w_rowMax;
      if (res_di != 8'd0)
        r_fgCnt <= r_fgCnt + (AW+1)'(1);
      // Strict compare keeps the earliest address on ties.
      if (res_di > r_peakVal) begin
        r_peakVal  <= res_di;
        r_peakAddr <= r_beatAddr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rmaxWr   <= 1'b0;
      r_rmaxAddr <= '0;
      r_rmaxDo   <= '0;
    end else begin
      r_rmaxWr <= r_beatVld && (w_col == LAST_COL);
      if (r_beatVld && (w_col == LAST_COL)) begin
        r_rmaxAddr <= w_row;
        r_rmaxDo   <= w_rowMax;
      end
    end
  end

  assign res_rd    = r_rd;
  assign res_addr  = r_addr;
  assign busy      = r_busy;
  assign scan_done = r_scanDone;
  assign peak_val  = r_peakVal;
  assign peak_addr = r_peakAddr;
  assign fg_cnt    = r_fgCnt;
  assign rmax_wr   = r_rmaxWr;
  assign rmax_addr = r_rmaxAddr;
  assign rmax_do   = r_rmaxDo;

endmodule

// File: doc/dt_peak_scan.md
# dt_peak_scan

Post-processing stage downstream of the distance-transform engine. Once the engine asserts `done`, this block scans the 128x128 8-bit distance map in the result memory in raster order and produces:
- the global peak value and its first address;
- the foreground pixel count;
- a per-row maximum written to a 128-entry row-max memory.

It is read-only on the result memory. The top level hands it the `res_*` read port while `busy` is high.

## Interface
Parameters:
- IMG_W, 128, image width in pixels (row length); power of two
- IMG_H, 128, image height in rows; IMG_W*IMG_H = 16384

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  level request, driven by the distance-transform `done`
- res_rd  output  1  result-memory read enable
- res_addr  output  14  result-memory read address
- res_di  input  8  read data; valid the cycle after `res_rd`/`res_addr` are presented
- rmax_wr  output  1  row-max memory write strobe
- rmax_addr  output  7  row index being written
- rmax_do  output  8  maximum distance in that row
- peak_val  output  8  largest distance in the image
- peak_addr  output  14  address of the first pixel holding `peak_val`
- fg_cnt  output  15  number of pixels with nonzero distance (0..16384)
- busy  output  1  scan in progress; owns the result-memory port
- scan_done  output  1  results valid; held until `start` drops or reset

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - if `start`=1, clear `peak_val`, `peak_addr`, `fg_cnt` and the row accumulator, then go to SCAN;
  - `busy` rises on entry to SCAN.
- SCAN:
  - issue one read per cycle, `res_rd`=1, address 0,1,...,16383;
  - after issuing 16383, go to DRAIN with `res_rd`=0.
- DRAIN: wait for the final data beat and the final row write, then go to DONE.
- DONE:
  - `busy`=0, `scan_done`=1, all result outputs stable;
  - when `start`=0, return to IDLE with `scan_done`=0. Results hold their values until the next accepted start.
- Data path on each returned beat with address a and value v:
  - if v != 0: `fg_cnt` += 1;
  - if v > `peak_val` (strictly greater): `peak_val`=v, `peak_addr`=a. Ties keep the earlier address.
  - row accumulator = v at column 0, otherwise max(acc, v).
- Row write:
  - at column IMG_W-1 the next cycle carries `rmax_wr`=1, `rmax_addr`=row, `rmax_do`=max(acc, v);
  - the strobe lasts exactly one cycle per row, 128 strobes per scan.
- Address width: row = a[13:7], column = a[6:0]. The address counter stops at 16383 and never wraps.
- `start` is ignored while in SCAN and DRAIN. Raising `start` in DONE has no effect until it has dropped.
- Reset (any time, including mid-scan):
  - all outputs go immediately to reset values: `res_rd`=0, `res_addr`=0, `rmax_wr`=0, `rmax_addr`=0, `rmax_do`=0, `peak_val`=0, `peak_addr`=0, `fg_cnt`=0, `busy`=0, `scan_done`=0;
  - the state returns to IDLE.

## Timing
- T is the first rising edge at which IDLE samples `start`=1.
- Address k is presented with `res_rd`=1 during cycle T+1+k. Data is captured at edge T+2+k.
- `busy`=1 from T+1 through T+16386.
- `rmax_wr` for row r is high in cycle T+130+128r. The last strobe is in cycle T+16386.
- `peak_val`, `peak_addr` and `fg_cnt` are final by cycle T+16386.
- `scan_done`=1 from T+16387. Total latency is 16387 cycles from start acceptance to `scan_done`.
- One read per cycle, no bubbles, no backpressure.
- Outputs are registered. `res_addr` and `res_rd` change only on clock edges, except under asynchronous reset.

## Test plan
- All-zero map, start held high -> 128 strobes with `rmax_do`=0; `peak_val`=0, `peak_addr`=0, `fg_cnt`=0; `scan_done` at T+16387.
- Single pixel value 9 at address 5000 (row 39, col 8) -> `peak_val`=9, `peak_addr`=5000, `fg_cnt`=1; only row 39 has `rmax_do`=9.
- Value 7 at addresses 300 and 12000, all else 3 -> `peak_val`=7, `peak_addr`=300, `fg_cnt`=16384.
- Row r filled with value r+1 (row 127 = 128) -> strobe r carries `rmax_do`=r+1 at cycle T+130+128r; `peak_addr`=16256.
- Reset asserted at T+8000, released, start reapplied -> outputs are 0 during reset; the rescan gives results identical to an uninterrupted run.
- `start` pulsed high during SCAN after dropping, then left high through DONE -> no restart; `scan_done` holds until `start`=0, then IDLE re-arms and a new start rescans.
